z80_int_ctrl: RTL and testbench

Interrupt controller owning the IFF1/IFF2 flip-flops and interrupt mode for the vz80core CPU. It applies EI/DI/RETN/IM effects at instruction boundaries and enforces the one-instruction EI shadow. It edge-detects NMI, arbitrates NMI over maskable INT, and handshakes acceptance with the core's sequencer. The block sits beside the register file and feeds iff1/iff2 into the z80fi retirement signals.

---
 rtl/z80_int_ctrl_if.sv | 42 ++++
 rtl/z80_int_ctrl.sv | 135 +++++++++++++
 tb/tb_z80_int_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/z80_int_ctrl_if.sv
// z80_int_ctrl_if
// Bundles the handshake and bus signals that pass between the vz80core
// sequencer and the interrupt controller.
//   master : the sequencer side. It drives instruction-retire qualifiers,
//            the NMI/INT requests and svc_ack, and it reads back
//            iff1/iff2/im and take_nmi/take_int.
//   slave  : the interrupt controller side (z80_int_ctrl).
// Signals:
//   insn_done, insn_ei, insn_di, insn_retn, insn_im : retire pulse and qualifiers
//   im_sel[1:0]                                     : mode operand of IM n
//   nmi, int_req                                    : interrupt requests
//   svc_ack                                         : sequencer began acceptance
//   iff1, iff2, im[1:0]                             : architectural interrupt state
//   take_nmi, take_int                              : accepted-interrupt indicators
interface z80_int_ctrl_if;
   logic       insn_done;
   logic       insn_ei;
   logic       insn_di;
   logic       insn_retn;
   logic       insn_im;
   logic [1:0] im_sel;
   logic       nmi;
   logic       int_req;
   logic       svc_ack;
   logic       iff1;
   logic       iff2;
   logic [1:0] im;
   logic       take_nmi;
   logic       take_int;

   modport master (
      output insn_done, insn_ei, insn_di, insn_retn, insn_im, im_sel,
      output nmi, int_req, svc_ack,
      input  iff1, iff2, im, take_nmi, take_int
   );

   modport slave (
      input  insn_done, insn_ei, insn_di, insn_retn, insn_im, im_sel,
      input  nmi, int_req, svc_ack,
      output iff1, iff2, im, take_nmi, take_int
   );
endinterface

// File: rtl/z80_int_ctrl.sv
// z80_int_ctrl
// Owns IFF1/IFF2 and the interrupt mode for vz80core. It applies
// EI/DI/RETN/IM at instruction boundaries, edge-detects NMI, arbitrates
// NMI over maskable INT, and holds take_nmi/take_int until the sequencer
// acknowledges with svc_ack.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : z80_int_ctrl_if.slave (retire qualifiers, requests, svc_ack in;
//           iff1/iff2/im and take_nmi/take_int out)
module z80_int_ctrl (
   input  logic          clk,
   input  logic          reset,
   z80_int_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SVC_NMI, SVC_INT} state_t;

   state_t     state_q;
   logic       iff1_q, iff2_q;
   logic [1:0] im_q;
   logic       nmi_prev_q, nmi_pend_q, ei_shadow_q;
   logic       take_nmi_q, take_int_q;

   logic       iff1_d, iff2_d, ei_shadow_d;
   logic [1:0] im_d;
   logic       nmiEdge, atBoundary, acceptNmi, acceptInt;

   // Post-instruction-effect values at a boundary. Effects apply in a fixed
   // order, so a later qualifier overrides an earlier one. The shadow is
   // cleared by the instruction that follows EI before acceptance is
   // evaluated. INT can therefore land after that instruction but never at
   // the EI boundary itself.
   always_comb begin
      iff1_d      = iff1_q;
      iff2_d      = iff2_q;
      im_d        = im_q;
      ei_shadow_d = ei_shadow_q;
      if (bus.insn_ei) begin
         iff1_d      = 1'b1;
         iff2_d      = 1'b1;
         ei_shadow_d = 1'b1;
      end
      if (bus.insn_di) begin
         iff1_d      = 1'b0;
         iff2_d      = 1'b0;
         ei_shadow_d = 1'b0;
      end
      if (bus.insn_retn) begin
         iff1_d = iff2_d;
      end
      if (bus.insn_im) begin
         im_d = (bus.im_sel == 2'd3) ? 2'd0 : bus.im_sel;
      end
      if (!bus.insn_ei) begin
         ei_shadow_d = 1'b0;
      end
   end

   // Acceptance decisions. NMI uses the pending flag registered before this
   // cycle, so an edge that coincides with insn_done waits for the next
   // boundary.
   always_comb begin
      nmiEdge    = bus.nmi && !nmi_prev_q;
      atBoundary = (state_q == IDLE) && bus.insn_done;
      acceptNmi  = atBoundary && nmi_pend_q;
      acceptInt  = atBoundary && !nmi_pend_q && bus.int_req && iff1_d &&
                   !ei_shadow_d && !bus.insn_ei && !bus.insn_di;
   end

   // Main FSM. The pending NMI is tracked in every state. Boundary effects
   // and acceptance are applied only in IDLE. An accepted interrupt is held
   // until svc_ack arrives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         iff1_q      <= 1'b0;
         iff2_q      <= 1'b0;
         im_q        <= 2'd0;
         nmi_prev_q  <= 1'b0;
         nmi_pend_q  <= 1'b0;
         ei_shadow_q <= 1'b0;
         take_nmi_q  <= 1'b0;
         take_int_q  <= 1'b0;
      end else begin
         nmi_prev_q <= bus.nmi;
         if (acceptNmi) begin
            nmi_pend_q <= nmiEdge;
         end else if (nmiEdge) begin
            nmi_pend_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (bus.insn_done) begin
                  im_q        <= im_d;
                  ei_shadow_q <= ei_shadow_d;
                  if (acceptNmi) begin
                     iff1_q     <= 1'b0;
                     iff2_q     <= iff1_d;
                     take_nmi_q <= 1'b1;
                     state_q    <= SVC_NMI;
                  end else if (acceptInt) begin
                     iff1_q     <= 1'b0;
                     iff2_q     <= 1'b0;
                     take_int_q <= 1'b1;
                     state_q    <= SVC_INT;
                  end else begin
                     iff1_q <= iff1_d;
                     iff2_q <= iff2_d;
                  end
               end
            end
            SVC_NMI, SVC_INT: begin
               if (bus.svc_ack) begin
                  take_nmi_q <= 1'b0;
                  take_int_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: begin
               take_nmi_q <= 1'b0;
               take_int_q <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign bus.iff1     = iff1_q;
   assign bus.iff2     = iff2_q;
   assign bus.im       = im_q;
   assign bus.take_nmi = take_nmi_q;
   assign bus.take_int = take_int_q;

endmodule

// File: tb/tb_z80_int_ctrl.sv
// tb_z80_int_ctrl
// Self-checking bench for z80_int_ctrl. Each scenario task builds a table
// of per-cycle stimulus vectors. Each vector carries the output word
// {iff1, iff2, im[1:0], take_nmi, take_int} expected after the next clock
// edge. That word is pushed to a scoreboard queue when the stimulus is
// driven, then popped and compared once the edge has produced the output.
module tb_z80_int_ctrl;

   typedef struct packed {
      logic       done, ei, di, retn, imf;
      logic [1:0] sel;
      logic       nmi, intr, ack;
      logic [5:0] exp;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [5:0] expQ[$];

   z80_int_ctrl_if bus ();

   z80_int_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // The two take outputs must never be high together in any cycle.
   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         if ((bus.take_nmi & bus.take_int) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL exclusive_take: take_nmi=%b take_int=%b required not both 1",
                     bus.take_nmi, bus.take_int);
         end
      end
   end

   function automatic vec_t mkVec(input logic done, ei, di, retn, imf,
                                  input logic [1:0] sel,
                                  input logic nmi, intr, ack,
                                  input logic [5:0] exp);
      vec_t v;
      v.done = done; v.ei = ei; v.di = di; v.retn = retn; v.imf = imf;
      v.sel = sel; v.nmi = nmi; v.intr = intr; v.ack = ack; v.exp = exp;
      return v;
   endfunction

   // Drives one cycle of stimulus onto the interface.
   task automatic applyStimulus(input vec_t v);
      bus.insn_done = v.done;
      bus.insn_ei   = v.ei;
      bus.insn_di   = v.di;
      bus.insn_retn = v.retn;
      bus.insn_im   = v.imf;
      bus.im_sel    = v.sel;
      bus.nmi       = v.nmi;
      bus.int_req   = v.intr;
      bus.svc_ack   = v.ack;
   endtask

   // Advances to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset values, then level INT with iff1 clear must never be taken.
   // svc_ack in IDLE has no effect.
   task automatic test_reset();
      vec_t v[$];
      logic [5:0] obs, want;
      applyStimulus(mkVec(0,0,0,0,0,2'd0,0,0,0,6'b0));
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      checks++;
      obs = {bus.iff1, bus.iff2, bus.im, bus.take_nmi, bus.take_int};
      if (obs !== 6'b000000) begin
         errors++;
         $display("[TB] FAIL reset_values: got %b required %b", obs, 6'b000000);
      end
      v.push_back(mkVec(1,0,0,0,0,2'd0,0,1,0,6'b000000));
      v.push_back(mkVec(0,0,0,0,0,2'd0,0,1,0,6'b000000));
      v.push_back(mkVec(1,0,0,0,0,2'd0,0,1,0,6'b000000));
      v.push_back(mkVec(0,0,0,0,0,2'd0,0,0,1,6'b000000));
      v.push_back(mkVec(0,0,0,0,0,2'd0,0,0,0,6'b000000));
      foreach (v[k]) begin
         applyStimulus(v[k]);
         expQ.push_back(v[k].exp);
         tick();
         obs  = {bus.iff1, bus.iff2, bus.im, bus.take_nmi, bus.take_int};
         want = expQ.pop_front();
         checks++;
         if (obs !== want) begin
            errors++;
            $display("[TB] FAIL reset[%0d]: got %b required %b", k, obs, want);
         end
      end
   endtask

   // EI enables without taking INT. The following instruction's boundary
   // takes INT, and svc_ack ends service.
   task automatic test_ei_int();
      vec_t v[$];
      logic [5:0] obs, want;
      v.push_back(mkVec(1,1,0,0,0,2'd0,0,1,0,6'b110000));
      v.push_back(mkVec(0,0,0,0,0,2'd0,0,1,0,6'b110000));
      v.push_back(mkVec(1,0,0,0,0,2'd0,0,1,0,6'b000001));
      v.push_back(mkVec(0,0,0,0,0,2'd0,0,1,0,6'b000001));
      v.push_back(mkVec(0,0,0,0,0,2'd0,0,0,1,6'b000000));
      v.push_back(mkVec(0,0,0,0,0,2'd0,0,0,0,6'b000000));
      foreach (v[k]) begin
         applyStimulus(v[k]);
         expQ.push_back(v[k].exp);
         tick();
         obs  = {bus.iff1, bus.iff2, bus.im, bus.take_nmi, bus.take_int};
         want = expQ.pop_front();
         checks++;
         if (obs !== want) begin
            errors++;
            $display("[TB] FAIL ei_int[%0d]: got %b required %b", k, obs, want);
         end
      end
   endtask

   // EI, EI, NOP: INT is taken only at the NOP boundary.
   task automatic test_back_to_back_ei();
      vec_t v[$];
      logic [5:0] obs, want;
      v.push_back(mkVec(1,1,0,0,0,2'd0,0,1,0,6'b110000));
      v.push_back(mkVec(1,1,0,0,0,2'd0,0,1,0,6'b110000));
      v.push_back(mkVec(1,0,0,0,0,2'd0,0,1,0,6'b000001));
      v.push_back(mkVec(0,0,0,0,0,2'd0,0,0,1,6'b000000));
      foreach (v[k]) begin
         applyStimulus(v[k]);
         expQ.push_back(v[k].exp);
         tick();
         obs  = {bus.iff1, bus.iff2, bus.im, bus.take_nmi, bus.take_int};
         want = expQ.pop_front();
         checks++;
         if (obs !== want) begin
            errors++;
            $display("[TB] FAIL back_to_back_ei[%0d]: got %b required %b", k, obs, want);
         end
      end
   endtask

   // NMI copies iff1 into iff2 and clears iff1. insn_done is ignored during
   // service, and RETN restores iff1. An NMI edge coincident with insn_done
   // waits for the next boundary.
   task automatic test_nmi();
      vec_t v[$];
      logic [5:0] obs, want;
      v.push_back(mkVec(1,1,0,0,0,2'd0,0,0,0,6'b110000));
      v.push_back(mkVec(1,0,0,0,0,2'd0,0,0,0,6'b110000));
      v.push_back(mkVec(0,0,0,0,0,2'd0,1,0,0,6'b110000));
      v.push_back(mkVec(1,0,0,0,0,2'd0,1,0,0,6'b010010));
      v.push_back(mkVec(1,0,1,0,0,2'd0,1,0,0,6'b010010));
      v.push_back(mkVec(0,0,0,0,0,2'd0,0,0,1,6'b010000));
      v.push_back(mkVec(1,0,0,1,0,2'd0,0,0,0,6'b110000));
      v.push_back(mkVec(1,0,0,0,0,2'd0,1,0,0,6'b110000));
      v.push_back(mkVec(1,0,0,0,0,2'd0,1,0,0,6'b010010));
      v.push_back(mkVec(0,0,0,0,0,2'd0,0,0,1,6'b010000));
      v.push_back(mkVec(1,0,0,1,0,2'd0,0,0,0,6'b110000));
      foreach (v[k]) begin
         applyStimulus(v[k]);
         expQ.push_back(v[k].exp);
         tick();
         obs  = {bus.iff1, bus.iff2, bus.im, bus.take_nmi, bus.take_int};
         want = expQ.pop_front();
         checks++;
         if (obs !== want) begin
            errors++;
            $display("[TB] FAIL nmi[%0d]: got %b required %b", k, obs, want);
         end
      end
   endtask

   // NMI beats a simultaneous INT. INT is then refused while iff1 is clear
   // and taken once RETN restores iff1.
   task automatic test_nmi_over_int();
      vec_t v[$];
      logic [5:0] obs, want;
      v.push_back(mkVec(0,0,0,0,0,2'd0,1,1,0,6'b110000));
      v.push_back(mkVec(1,0,0,0,0,2'd0,1,1,0,6'b010010));
      v.push_back(mkVec(0,0,0,0,0,2'd0,0,1,1,6'b010000));
      v.push_back(mkVec(1,0,0,0,0,2'd0,0,1,0,6'b010000));
      v.push_back(mkVec(1,0,0,1,0,2'd0,0,1,0,6'b000001));
      v.push_back(mkVec(0,0,0,0,0,2'd0,0,0,1,6'b000000));
      foreach (v[k]) begin
         applyStimulus(v[k]);
         expQ.push_back(v[k].exp);
         tick();
         obs  = {bus.iff1, bus.iff2, bus.im, bus.take_nmi, bus.take_int};
         want = expQ.pop_front();
         checks++;
         if (obs !== want) begin
            errors++;
            $display("[TB] FAIL nmi_over_int[%0d]: got %b required %b", k, obs, want);
         end
      end
   endtask

   // IM 2 / IM 3 (treated as 0) / IM 1. Reset is then asserted mid-service
   // while an NMI is pending; reset must drop take_int at once and discard
   // the pending NMI.
   task automatic test_im_reset();
      vec_t v[$];
      logic [5:0] obs, want;
      v.push_back(mkVec(1,0,0,0,1,2'd2,0,0,0,6'b001000));
      v.push_back(mkVec(1,0,0,0,1,2'd3,0,0,0,6'b000000));
      v.push_back(mkVec(1,0,0,0,1,2'd1,0,0,0,6'b000100));
      v.push_back(mkVec(1,1,0,0,0,2'd0,0,0,0,6'b110100));
      v.push_back(mkVec(1,0,0,0,0,2'd0,0,1,0,6'b000101));
      v.push_back(mkVec(0,0,0,0,0,2'd0,1,0,0,6'b000101));
      foreach (v[k]) begin
         applyStimulus(v[k]);
         expQ.push_back(v[k].exp);
         tick();
         obs  = {bus.iff1, bus.iff2, bus.im, bus.take_nmi, bus.take_int};
         want = expQ.pop_front();
         checks++;
         if (obs !== want) begin
            errors++;
            $display("[TB] FAIL im_reset[%0d]: got %b required %b", k, obs, want);
         end
      end
      #2;
      reset   = 1'b1;
      bus.nmi = 1'b0;
      #1;
      checks++;
      obs = {bus.iff1, bus.iff2, bus.im, bus.take_nmi, bus.take_int};
      if (obs !== 6'b000000) begin
         errors++;
         $display("[TB] FAIL async_reset: got %b required %b", obs, 6'b000000);
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
      applyStimulus(mkVec(1,0,0,0,0,2'd0,0,0,0,6'b000000));
      expQ.push_back(6'b000000);
      tick();
      obs  = {bus.iff1, bus.iff2, bus.im, bus.take_nmi, bus.take_int};
      want = expQ.pop_front();
      checks++;
      if (obs !== want) begin
         errors++;
         $display("[TB] FAIL nmi_discarded: got %b required %b", obs, want);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      $display("[TB] starting z80_int_ctrl bench");
      test_reset();
      test_ei_int();
      test_back_to_back_ei();
      test_nmi();
      test_nmi_over_int();
      test_im_reset();
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
